// File: rtl/uvma_obi_rtl_pkg.sv
// Shared helpers for the OBI slave memory responder: data-width legality and
// handshake parity checking.
package uvma_obi_rtl_pkg;

    localparam int DATA_WIDTH_NARROW = 32;
    localparam int DATA_WIDTH_WIDE   = 64;

    function automatic bit data_width_legal(input int w);
        return (w == DATA_WIDTH_NARROW) || (w == DATA_WIDTH_WIDE);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 1) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction

    // A signal and its odd-parity companion are consistent when they differ.
    function automatic logic par_ok(input logic sig, input logic par);
        return sig ^ par;
    endfunction

endpackage

// File: rtl/uvma_obi_rsp_fifo.sv
// Synchronous in-order FIFO with extra-bit wrapping pointers; storage is not
// reset, only the pointers are.
module uvma_obi_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int IW = (PW > 0) ? PW : 1;

    logic [WIDTH-1:0] store_q [2**IW];
    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic [IW-1:0]    widx, ridx;
    logic             do_push, do_pop;

    generate
        if (PW == 0) begin : g_single
            assign widx = '0;
            assign ridx = '0;
        end else begin : g_multi
            assign widx = wptr_q[PW-1:0];
            assign ridx = rptr_q[PW-1:0];
        end
    endgenerate

    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (count_o == (PW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = store_q[ridx];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[widx] <= data_i;
    end

endmodule

// File: rtl/uvma_obi_slv_mem.sv
// OBI slave memory responder: byte-enabled word memory, range-based error
// decode, in-order buffered responses and sticky handshake parity checking.
module uvma_obi_slv_mem
    import uvma_obi_rtl_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ID_WIDTH        = 4,
    parameter int                    MEM_DEPTH       = 1024,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE        = 'hFFFF_F000,
    parameter logic [ADDR_WIDTH-1:0] ERR_SIZE        = 'h1000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req,
    input  logic                                   we,
    input  logic [ADDR_WIDTH-1:0]                  addr,
    input  logic [DATA_WIDTH/8-1:0]                be,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    input  logic [ID_WIDTH-1:0]                    aid,
    input  logic                                   reqpar,
    output logic                                   gnt,
    output logic                                   gntpar,
    output logic                                   rvalid,
    output logic                                   rvalidpar,
    input  logic                                   rready,
    input  logic                                   rreadypar,
    output logic [DATA_WIDTH-1:0]                  rdata,
    output logic                                   err,
    output logic [ID_WIDTH-1:0]                    rid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   par_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BE_W);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BE_W);
    localparam logic [ADDR_WIDTH:0] ERR_LO    = {1'b0, ERR_BASE};
    localparam logic [ADDR_WIDTH:0] ERR_HI    = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};

    generate
        if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
            $error("uvma_obi_slv_mem: DATA_WIDTH must be 32 or 64");
        end
        if (!depth_legal(MAX_OUTSTANDING)) begin : g_bad_outstanding
            $error("uvma_obi_slv_mem: MAX_OUTSTANDING must be a power of 2 in 1..16");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [ID_WIDTH-1:0]   rid;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  par_err_q, par_err_d;
    logic [ADDR_WIDTH:0]   addr_x;
    logic [IDX_W-1:0]      word_idx;
    logic                  in_err_win, addr_err;
    logic                  accept, pop;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    rsp_t                  rsp_push, rsp_head;

    assign addr_x     = {1'b0, addr};
    assign word_idx   = addr[LSB +: IDX_W];
    assign in_err_win = (ERR_SIZE != '0) && (addr_x >= ERR_LO) && (addr_x < ERR_HI);
    assign addr_err   = (addr_x >= MEM_BYTES) || in_err_win;

    // Grant depends only on occupancy and reset, so a pop never opens gnt in
    // the same cycle.
    assign gnt    = !fifo_full && !reset;
    assign gntpar = ~gnt;
    assign accept = req && gnt;
    assign pop    = !fifo_empty && rready;

    always_comb begin
        rsp_push.rid   = aid;
        rsp_push.err   = addr_err;
        rsp_push.rdata = (we || addr_err) ? '0 : mem_q[word_idx];
    end

    always_ff @(posedge clk) begin
        if (accept && we && !addr_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    uvma_obi_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (rsp_push),
        .data_o  (rsp_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head fields are masked while empty so idle outputs read as zero.
    assign rvalid      = !fifo_empty;
    assign rvalidpar   = ~rvalid;
    assign rdata       = rvalid ? rsp_head.rdata : '0;
    assign err         = rvalid ? rsp_head.err   : 1'b0;
    assign rid         = rvalid ? rsp_head.rid   : '0;
    assign outstanding = fifo_count;

    always_comb begin
        par_err_d = par_err_q;
        if (!par_ok(req, reqpar) || !par_ok(rready, rreadypar)) par_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) par_err_q <= 1'b0;
        else       par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;

endmodule

// File: tb/tb_uvma_obi_slv_mem.sv
// Directed self-checking bench for uvma_obi_slv_mem with default parameters.
module tb_uvma_obi_slv_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, reqpar;
    logic [31:0] addr, wdata;
    logic [3:0]  be, aid;
    logic        gnt, gntpar, rvalid, rvalidpar;
    logic        rready, rreadypar;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
    logic [2:0]  outstanding;
    logic        par_err;

    int n_tests = 0;
    int n_fail  = 0;

    uvma_obi_slv_mem dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .be          (be),
        .wdata       (wdata),
        .aid         (aid),
        .reqpar      (reqpar),
        .gnt         (gnt),
        .gntpar      (gntpar),
        .rvalid      (rvalid),
        .rvalidpar   (rvalidpar),
        .rready      (rready),
        .rreadypar   (rreadypar),
        .rdata       (rdata),
        .err         (err),
        .rid         (rid),
        .outstanding (outstanding),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d, input logic [3:0] id);
        req    = r;
        reqpar = ~r;
        we     = w;
        addr   = a;
        be     = b;
        wdata  = d;
        aid    = id;
    endtask

    task automatic set_rready(input logic r);
        rready    = r;
        rreadypar = ~r;
    endtask

    // One transaction with rready high: accepted on the next edge, response
    // visible the cycle after, retired on the following edge.
    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input logic [3:0] id,
                        input logic exp_err, input logic [31:0] exp_rdata);
        set_req(1'b1, w, a, b, d, id);
        #1 chk({tag, ".gnt"}, gnt, 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        chk({tag, ".rvalid"}, rvalid, 1);
        chk({tag, ".rid"}, rid, id);
        chk({tag, ".err"}, err, exp_err);
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".outstanding"}, outstanding, 1);
        @(posedge clk); #1;
        chk({tag, ".retired"}, rvalid, 0);
        chk({tag, ".idle_cnt"}, outstanding, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        set_rready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt", gnt, 0);
        chk("rst.gntpar", gntpar, 1);
        chk("rst.rvalid", rvalid, 0);
        chk("rst.rvalidpar", rvalidpar, 1);
        chk("rst.rdata", rdata, 0);
        chk("rst.err", err, 0);
        chk("rst.rid", rid, 0);
        chk("rst.outstanding", outstanding, 0);
        chk("rst.par_err", par_err, 0);
        reset = 1'b0;
        #1 chk("rst.gnt_release", gnt, 1);
        chk("rst.gntpar_release", gntpar, 0);
        @(posedge clk); #1;

        xact("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd3, 1'b0, 32'h0);
        xact("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 4'd5, 1'b0, 32'hDEADBEEF);
        xact("wr20", 1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, 4'd1, 1'b0, 32'h0);
        xact("wr20be", 1'b1, 32'h20, 4'b0101, 32'h11223344, 4'd2, 1'b0, 32'h0);
        xact("rd20", 1'b0, 32'h20, 4'hF, 32'h0, 4'd4, 1'b0, 32'hAA22AA44);
        xact("rd10be0", 1'b0, 32'h10, 4'h0, 32'h0, 4'd6, 1'b0, 32'hDEADBEEF);
        xact("rdwin", 1'b0, 32'hFFFF_F004, 4'hF, 32'h0, 4'd7, 1'b1, 32'h0);
        xact("rdoor", 1'b0, 32'h0000_1000, 4'hF, 32'h0, 4'd8, 1'b1, 32'h0);
        xact("wroor", 1'b1, 32'h0000_1010, 4'hF, 32'h12345678, 4'd9, 1'b1, 32'h0);
        xact("rd10keep", 1'b0, 32'h10, 4'hF, 32'h0, 4'd10, 1'b0, 32'hDEADBEEF);
        xact("wrlast", 1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 4'd11, 1'b0, 32'h0);
        xact("rdlast", 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 4'd12, 1'b0, 32'hCAFEF00D);

        // Back-to-back reads with rready held high.
        set_req(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 4'd1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 4'd2);
        chk("b2b.rvalid0", rvalid, 1);
        chk("b2b.rid0", rid, 1);
        chk("b2b.rdata0", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        chk("b2b.rvalid1", rvalid, 1);
        chk("b2b.rid1", rid, 2);
        chk("b2b.rdata1", rdata, 32'hAA22AA44);
        chk("b2b.outstanding", outstanding, 1);
        @(posedge clk); #1;
        chk("b2b.drained", rvalid, 0);

        // Fill the response buffer with rready low.
        set_rready(1'b0);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 4'(i));
            #1 chk($sformatf("fill.gnt%0d", i), gnt, 1);
            @(posedge clk); #1;
        end
        chk("full.gnt", gnt, 0);
        chk("full.gntpar", gntpar, 1);
        chk("full.outstanding", outstanding, 4);
        chk("full.rvalidpar", rvalidpar, 0);
        chk("full.rid", rid, 0);
        @(posedge clk); #1;
        chk("full.hold_cnt", outstanding, 4);
        chk("full.hold_rid", rid, 0);
        chk("full.hold_rdata", rdata, 32'hDEADBEEF);
        set_rready(1'b1);
        #1 chk("full.gnt_pop_pending", gnt, 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        set_rready(1'b0);
        chk("pop.outstanding", outstanding, 3);
        chk("pop.gnt", gnt, 1);
        chk("pop.rid", rid, 1);

        // Reset with three responses pending.
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst.rvalid", rvalid, 0);
        chk("midrst.outstanding", outstanding, 0);
        reset = 1'b0;
        set_rready(1'b1);
        #1;
        xact("rd10post", 1'b0, 32'h10, 4'hF, 32'h0, 4'd13, 1'b0, 32'hDEADBEEF);

        // Parity violations are sticky until reset.
        chk("par.clean", par_err, 0);
        reqpar = req;
        @(posedge clk); #1;
        reqpar = ~req;
        chk("par.req_set", par_err, 1);
        repeat (3) @(posedge clk);
        #1 chk("par.req_held", par_err, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("par.cleared", par_err, 0);
        rreadypar = rready;
        @(posedge clk); #1;
        set_rready(1'b1);
        chk("par.rready_set", par_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
